// File: rtl/sc_run_controller.sv
// Run controller for the single-cycle CPU: sequences CPU reset, gates its clock
// enable, counts RUN cycles and stops on halt or when the cycle budget runs out.
module sc_run_controller #(
  parameter int CW           = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter int DRAIN_CYCLES = 2,
  parameter int AUTO_START   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  output logic          cpu_rst_n,
  output logic          cpu_clk_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [CW-1:0] LP_RST_LAST    = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LP_DRN_LAST    = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LP_BUDGET_LAST = CW'(MAX_CYCLES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_phase;
  logic [CW-1:0] r_count;
  logic          r_first;
  logic          r_timeout;
  logic          r_cpu_rst_n;
  logic          r_clk_en;
  logic          r_busy;
  logic          r_done;
  logic          w_budget_last;
  logic          w_enter_reset;

  assign w_budget_last = (r_count == LP_BUDGET_LAST);
  assign w_enter_reset = (w_next == ST_RESET) && (r_state != ST_RESET);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // r_first marks the first edge after reset release for auto-start
        if (start || ((AUTO_START != 0) && r_first)) w_next = ST_RESET;
      end
      ST_RESET: begin
        if (r_phase == LP_RST_LAST) w_next = ST_RUN;
      end
      ST_RUN: begin
        // halt has priority over budget exhaustion on the same cycle
        if (halt)               w_next = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        else if (w_budget_last) w_next = ST_DONE;
      end
      ST_DRAIN: begin
        if (r_phase == LP_DRN_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) w_next = ST_RESET;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_count     <= '0;
      r_first     <= 1'b1;
      r_timeout   <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_clk_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= 1'b0;
      // phase counter restarts on every state change
      if (w_next != r_state) r_phase <= '0;
      else                   r_phase <= r_phase + CW'(1);

      if (w_enter_reset) begin
        r_count   <= '0;
        r_timeout <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_count <= r_count + CW'(1);
        if (!halt && w_budget_last) r_timeout <= 1'b1;
      end

      // outputs are registered from the next state so they line up with r_state
      r_cpu_rst_n <= (w_next == ST_RUN) || (w_next == ST_DRAIN) || (w_next == ST_DONE);
      r_clk_en    <= (w_next == ST_RESET) || (w_next == ST_RUN) || (w_next == ST_DRAIN);
      r_busy      <= (w_next == ST_RESET) || (w_next == ST_RUN) || (w_next == ST_DRAIN);
      r_done      <= (w_next == ST_DONE);
    end
  end

  assign cpu_rst_n   = r_cpu_rst_n;
  assign cpu_clk_en  = r_clk_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_count;

endmodule

// File: tb/tb_sc_run_controller.sv
// Bench for sc_run_controller: directed table and sequences on two fixed
// configurations plus random halt/start/reset traffic against a timeline model.
module tb_sc_run_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance A: default parameters
  logic a_rst, a_start, a_halt, a_rn, a_en, a_busy, a_done, a_to;
  logic [31:0] a_cnt;
  // instance B: MAX_CYCLES=10, DRAIN_CYCLES=0, AUTO_START=0
  logic b_rst, b_start, b_halt, b_rn, b_en, b_busy, b_done, b_to;
  logic [31:0] b_cnt;
  // instance X: random traffic
  logic x_rst, x_start, x_halt, x_rn, x_en, x_busy, x_done, x_to;
  logic [7:0] x_cnt;

  localparam int XR = 3, XMAX = 12, XD = 3;

  sc_run_controller u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .halt(a_halt),
    .cpu_rst_n(a_rn), .cpu_clk_en(a_en), .busy(a_busy), .done(a_done),
    .timeout(a_to), .cycle_count(a_cnt));

  sc_run_controller #(.MAX_CYCLES(10), .DRAIN_CYCLES(0), .AUTO_START(0)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .halt(b_halt),
    .cpu_rst_n(b_rn), .cpu_clk_en(b_en), .busy(b_busy), .done(b_done),
    .timeout(b_to), .cycle_count(b_cnt));

  sc_run_controller #(.CW(8), .RESET_CYCLES(XR), .MAX_CYCLES(XMAX),
                      .DRAIN_CYCLES(XD), .AUTO_START(1)) u_x (
    .clk(clk), .rst(x_rst), .start(x_start), .halt(x_halt),
    .cpu_rst_n(x_rn), .cpu_clk_en(x_en), .busy(x_busy), .done(x_done),
    .timeout(x_to), .cycle_count(x_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input int rn, input int en, input int bz,
                       input int dn, input int to, input int cnt);
    chk({nm, ".cpu_rst_n"}, 32'(a_rn), rn);
    chk({nm, ".cpu_clk_en"}, 32'(a_en), en);
    chk({nm, ".busy"}, 32'(a_busy), bz);
    chk({nm, ".done"}, 32'(a_done), dn);
    chk({nm, ".timeout"}, 32'(a_to), to);
    chk({nm, ".cycle_count"}, a_cnt, cnt);
  endtask

  task automatic chk_b(input string nm, input int rn, input int en, input int bz,
                       input int dn, input int to, input int cnt);
    chk({nm, ".cpu_rst_n"}, 32'(b_rn), rn);
    chk({nm, ".cpu_clk_en"}, 32'(b_en), en);
    chk({nm, ".busy"}, 32'(b_busy), bz);
    chk({nm, ".done"}, 32'(b_done), dn);
    chk({nm, ".timeout"}, 32'(b_to), to);
    chk({nm, ".cycle_count"}, b_cnt, cnt);
  endtask

  // directed vector table for instance B
  typedef struct {
    logic s; logic h;
    int rn; int en; int bz; int dn; int to; int cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic s, input logic h, input int rn, input int en,
                              input int bz, input int dn, input int to, input int cnt);
    vec_t v;
    v.s = s; v.h = h; v.rn = rn; v.en = en; v.bz = bz; v.dn = dn; v.to = to; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  // timeline model for instance X: a run is described by the number of edges
  // since it began (m_t) and the edge index at which RUN ended (m_end)
  localparam int PH_IDLE = 0, PH_RESET = 1, PH_RUN = 2, PH_DRAIN = 3, PH_DONE = 4;
  int m_act, m_first, m_t, m_end, m_dl, m_cnt, m_to;

  function automatic int m_phase();
    if (m_act == 0)                return PH_IDLE;
    if (m_t < XR)                  return PH_RESET;
    if (m_end < 0)                 return PH_RUN;
    if (m_t < m_end + m_dl)        return PH_DRAIN;
    return PH_DONE;
  endfunction

  function automatic void m_reset();
    m_act = 0; m_first = 1; m_t = 0; m_end = -1; m_dl = 0; m_cnt = 0; m_to = 0;
  endfunction

  function automatic void m_begin();
    m_act = 1; m_t = 0; m_end = -1; m_dl = 0; m_cnt = 0; m_to = 0;
  endfunction

  function automatic void m_edge(input logic s, input logic h);
    int ph;
    int k;
    ph = m_phase();
    if (ph == PH_IDLE) begin
      if (s || (m_first != 0)) m_begin();
    end else if (ph == PH_DONE) begin
      if (s) m_begin();
    end else begin
      if (ph == PH_RUN) begin
        k = m_t - XR + 1;
        m_cnt = k;
        if (h) begin
          m_end = m_t + 1; m_dl = XD;
        end else if (k == XMAX) begin
          m_end = m_t + 1; m_dl = 0; m_to = 1;
        end
      end
      m_t++;
    end
    m_first = 0;
  endfunction

  task automatic chk_x();
    int ph;
    ph = m_phase();
    chk("rnd.cpu_rst_n", 32'(x_rn), (ph == PH_RUN || ph == PH_DRAIN || ph == PH_DONE) ? 1 : 0);
    chk("rnd.cpu_clk_en", 32'(x_en), (ph == PH_RESET || ph == PH_RUN || ph == PH_DRAIN) ? 1 : 0);
    chk("rnd.busy", 32'(x_busy), (ph == PH_RESET || ph == PH_RUN || ph == PH_DRAIN) ? 1 : 0);
    chk("rnd.done", 32'(x_done), (ph == PH_DONE) ? 1 : 0);
    chk("rnd.timeout", 32'(x_to), m_to);
    chk("rnd.cycle_count", 32'(x_cnt), m_cnt);
  endtask

  initial begin
    a_rst = 1'b0; a_start = 1'b0; a_halt = 1'b0;
    b_rst = 1'b0; b_start = 1'b0; b_halt = 1'b0;
    x_rst = 1'b0; x_start = 1'b0; x_halt = 1'b0;

    // table: idle without auto-start, ignored start in RUN, halt on last budget
    // cycle, restart from DONE, then a plain timeout
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(k == 3, 0, 1, 1, 1, 0, 0, k);
    add(0, 1, 1, 0, 0, 1, 0, 10);
    add(0, 1, 1, 0, 0, 1, 0, 10);
    add(1, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 1, 1, 1, 0, 0, k);
    add(0, 0, 1, 0, 0, 1, 1, 10);
    add(0, 0, 1, 0, 0, 1, 1, 10);

    #12;
    chk_a("rst_a", 0, 0, 0, 0, 0, 0);
    chk_b("rst_b", 0, 0, 0, 0, 0, 0);
    a_rst = 1'b1;
    b_rst = 1'b1;

    // A: auto-start, halt tied low, full budget timeout
    tick(); chk_a("a_reset1", 0, 1, 1, 0, 0, 0);
    tick(); chk_a("a_reset2", 0, 1, 1, 0, 0, 0);
    tick(); chk_a("a_run0", 1, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 999; i++) tick();
    chk_a("a_run999", 1, 1, 1, 0, 0, 999);
    tick(); chk_a("a_timeout", 1, 0, 0, 1, 1, 1000);
    tick(); chk_a("a_hold", 1, 0, 0, 1, 1, 1000);

    // A: restart, halt on RUN cycle 37, drain with halt still high
    a_start = 1'b1;
    tick(); chk_a("a2_reset1", 0, 1, 1, 0, 0, 0);
    a_start = 1'b0;
    tick(); tick(); chk_a("a2_run0", 1, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 36; i++) tick();
    a_halt = 1'b1;
    tick(); chk_a("a2_drain1", 1, 1, 1, 0, 0, 37);
    tick(); chk_a("a2_drain2", 1, 1, 1, 0, 0, 37);
    a_halt = 1'b0;
    tick(); chk_a("a2_done", 1, 0, 0, 1, 0, 37);

    // A: asynchronous reset mid-run, then fresh auto-started run
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick(); tick();
    for (int i = 1; i <= 20; i++) tick();
    chk_a("a3_run20", 1, 1, 1, 0, 0, 20);
    #2 a_rst = 1'b0;
    #1 chk_a("a3_async", 0, 0, 0, 0, 0, 0);
    @(negedge clk) a_rst = 1'b1;
    tick(); chk_a("a3_reset1", 0, 1, 1, 0, 0, 0);
    tick(); tick(); tick(); chk_a("a3_run1", 1, 1, 1, 0, 0, 1);

    // B: table vectors
    for (int i = 0; i < tbl.size(); i++) begin
      b_start = tbl[i].s;
      b_halt  = tbl[i].h;
      tick();
      chk_b($sformatf("tbl%0d", i), tbl[i].rn, tbl[i].en, tbl[i].bz, tbl[i].dn,
            tbl[i].to, tbl[i].cnt);
    end
    b_start = 1'b0; b_halt = 1'b0;

    // B: zero drain, halt on RUN cycle 5, then restart clears results
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick(); tick(); chk_b("b4_run0", 1, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) tick();
    b_halt = 1'b1;
    tick(); chk_b("b4_done", 1, 0, 0, 1, 0, 5);
    b_halt = 1'b0;
    b_start = 1'b1;
    tick(); chk_b("b4_reset1", 0, 1, 1, 0, 0, 0);
    b_start = 1'b0;
    tick(); chk_b("b4_reset2", 0, 1, 1, 0, 0, 0);
    tick(); chk_b("b4_run0b", 1, 1, 1, 0, 0, 0);

    // X: random traffic against the timeline model
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      x_halt  = ($urandom_range(7) == 0);
      x_start = ($urandom_range(11) == 0);
      if (x_rst == 1'b0) begin
        x_rst = 1'b1;
      end else if ($urandom_range(149) == 0) begin
        x_rst = 1'b0;
        m_reset();
      end
      @(posedge clk);
      if (x_rst) m_edge(x_start, x_halt);
      #1;
      chk_x();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_run_controller.md
Name: sc_run_controller

Overview:
- Synthesizable run-control block that drives the single-cycle CPU the way the simulation harness does: it sequences the CPU reset, gates the CPU clock enable, counts executed cycles, and stops on a halt or a cycle limit.
- Sits between board/top-level reset and `SC_CPU`. Allows a program to run on hardware with a bounded cycle budget and a reported cycle count.

Parameters:
- `CW`, 32: cycle counter width.
- `RESET_CYCLES`, 2: cycles `cpu_rst_n` is held low per run (≥1).
- `MAX_CYCLES`, 1000: RUN-cycle budget before timeout (≥1, < 2^CW).
- `DRAIN_CYCLES`, 2: cycles the CPU keeps clocking after halt so in-flight writes retire (0 allowed).
- `AUTO_START`, 1: 1 = start a run automatically once `rst` deasserts.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  run request, sampled on each rising edge
- `halt`  in  1  CPU halt indication (e.g. ecall/ebreak decode), level
- `cpu_rst_n`  out  1  active-low reset to CPU
- `cpu_clk_en`  out  1  CPU clock enable
- `busy`  out  1  high in RESET, RUN and DRAIN
- `done`  out  1  high in DONE
- `timeout`  out  1  run ended on budget, not halt; valid while `done`
- `cycle_count`  out  CW  RUN cycles consumed

Behaviour:
- Reset (`rst`=0, any time, asynchronous):
  - state = IDLE.
  - `cpu_rst_n`=0, `cpu_clk_en`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0.
  - Reset mid-run aborts immediately. No partial results are retained.
- All outputs are registered; state transitions occur on the rising edge of `clk`.
- IDLE:
  - `cpu_rst_n`=0, `cpu_clk_en`=0.
  - Go to RESET on `start`=1, or on the first edge after `rst` release if `AUTO_START`=1.
- RESET:
  - `cpu_rst_n`=0, `cpu_clk_en`=1, `busy`=1.
  - Internal counter runs exactly `RESET_CYCLES` cycles, then goes to RUN.
  - `cycle_count`, `timeout` and `done` are cleared on entry.
- RUN:
  - `cpu_rst_n`=1, `cpu_clk_en`=1.
  - `cycle_count` increments on every edge taken while in RUN, including the exit edge. If `halt` is first seen on the Nth RUN cycle, `cycle_count`=N after the exit.
  - `halt`=1: go to DRAIN, or to DONE if `DRAIN_CYCLES`=0. `timeout` stays 0.
  - `halt`=0 on the cycle where `cycle_count`==`MAX_CYCLES`-1: go to DONE with `timeout`=1 and `cycle_count`=`MAX_CYCLES`.
  - `halt` and budget exhaustion on the same cycle: halt wins, `timeout`=0, `cycle_count`=`MAX_CYCLES`.
- DRAIN:
  - `cpu_clk_en`=1; `cycle_count` frozen.
  - Exactly `DRAIN_CYCLES` cycles, then DONE. `halt` is ignored.
- DONE:
  - `cpu_clk_en`=0, `cpu_rst_n`=1 (CPU state held for inspection).
  - `done`=1, `busy`=0; `cycle_count` and `timeout` held.
  - `start`=1: go to RESET, which clears `done`, `timeout` and `cycle_count` on the next edge.
- `start` is ignored in RESET, RUN and DRAIN (no queuing).
- Counter never wraps: the `MAX_CYCLES` limit guarantees termination.
- `halt` is asserted before the CPU leaves reset: it is ignored outside RUN.

Test Plan:
- Defaults, `AUTO_START`=1, `halt` tied 0; release `rst` → `cpu_rst_n` low for 2 cycles, then 1000 RUN cycles, then `done`=1, `timeout`=1, `cycle_count`=1000, `cpu_clk_en`=0.
- `halt` pulsed on the 37th RUN cycle → DRAIN keeps `cpu_clk_en`=1 for 2 more cycles, then `done`=1, `timeout`=0, `cycle_count`=37.
- `MAX_CYCLES`=10, `halt` asserted on RUN cycle 10 → `timeout`=0, `cycle_count`=10 (halt priority).
- `DRAIN_CYCLES`=0, `halt` on RUN cycle 5 → `done`=1 on the following edge, `cycle_count`=5; then `start` pulse → `done`=0, `cycle_count`=0, `cpu_rst_n`=0 for 2 cycles, new run starts.
- `AUTO_START`=0 → stays IDLE with `cpu_rst_n`=0 indefinitely; `start` pulse during RUN has no effect on count or state.
- Drop `rst` during RUN at `cycle_count`=20 → all outputs immediately 0 (`cpu_rst_n`=0) without waiting for a clock edge; after release with `AUTO_START`=1, a fresh run counts from 0.
